// File: rtl/comparador_secuencial.sv
// comparador_secuencial: sequential K-bit unsigned comparator, one M-bit digit
// per clock. It runs MSB-first with early exit, or LSB-first over every digit.
// Results are registered and presented with a one-cycle valido pulse.
module comparador_secuencial #(
  parameter  int K = 4,
  parameter  int M = 1,
  localparam int D = (M >= 1) ? K / M : 1,
  localparam int C = $clog2(D) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic         modo,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  output logic         listo,
  output logic         valido,
  output logic         MAYOR,
  output logic         IGUAL,
  output logic         MENOR,
  output logic         Z,
  output logic [C-1:0] PASOS
);

  generate
    if (M < 1 || (K % M) != 0) begin : g_param_error
      $error("comparador_secuencial: M must be >= 1 and divide K");
    end
  endgenerate

  typedef enum logic [1:0] {REPOSO, COMPARA, FIN} estado_t;
  typedef enum logic [1:0] {RES_IGUAL, RES_MAYOR, RES_MENOR} resultado_t;

  localparam logic [C-1:0] ULTIMO = C'(D - 1);

  estado_t    estado, estado_sig;
  logic [K-1:0] reg_a, reg_b;
  logic         reg_modo;
  resultado_t   parcial, parcial_sig;
  logic [C-1:0] contador;
  logic [M-1:0] dig_a, dig_b;
  logic         fin_compara;

  // State register
  always_ff @(posedge clk) begin
    if (reset) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  // Digit selection, partial-result update and termination condition.
  // In MSB-first mode the partial result stays "equal" until the first
  // differing digit, so a single update rule serves both directions.
  always_comb begin
    dig_a       = reg_modo ? reg_a[M-1:0] : reg_a[K-1 -: M];
    dig_b       = reg_modo ? reg_b[M-1:0] : reg_b[K-1 -: M];
    parcial_sig = parcial;
    if (dig_a > dig_b)      parcial_sig = RES_MAYOR;
    else if (dig_a < dig_b) parcial_sig = RES_MENOR;
    fin_compara = (contador == ULTIMO) || (!reg_modo && (dig_a != dig_b));
  end

  // Next-state logic
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (inicio) estado_sig = COMPARA;
      COMPARA: if (fin_compara) estado_sig = FIN;
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    listo  = (estado == REPOSO);
    valido = (estado == FIN);
  end

  // Datapath: operand capture, digit shifting, counting and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_a    <= '0;
      reg_b    <= '0;
      reg_modo <= 1'b0;
      parcial  <= RES_IGUAL;
      contador <= '0;
      MAYOR    <= 1'b0;
      IGUAL    <= 1'b0;
      MENOR    <= 1'b0;
      PASOS    <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            reg_a    <= A;
            reg_b    <= B;
            reg_modo <= modo;
            parcial  <= RES_IGUAL;
            contador <= '0;
          end
        end
        COMPARA: begin
          if (reg_modo) begin
            reg_a <= reg_a >> M;
            reg_b <= reg_b >> M;
          end else begin
            reg_a <= reg_a << M;
            reg_b <= reg_b << M;
          end
          parcial  <= parcial_sig;
          contador <= contador + C'(1);
          if (fin_compara) begin
            MAYOR <= (parcial_sig == RES_MAYOR);
            IGUAL <= (parcial_sig == RES_IGUAL);
            MENOR <= (parcial_sig == RES_MENOR);
            PASOS <= contador + C'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Z = MAYOR;

endmodule

// File: tb/tb_comparador_secuencial.sv
// Scoreboard bench for comparador_secuencial: stimulus pushes expected results,
// per-instance monitors pop and compare on every valido pulse.
module tb_comparador_secuencial;

  typedef struct {
    bit may;
    bit igu;
    bit men;
    int pasos;
    int acc;
  } esperado_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int ciclo = 0;
  always @(posedge clk) ciclo <= ciclo + 1;

  int tests = 0;
  int failed = 0;

  // K=4, M=1 instance
  logic       inicio = 1'b0, modo = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       listo, valido, mayor, igual, menor, z;
  logic [2:0] pasos;

  comparador_secuencial #(.K(4), .M(1)) u_k4m1 (
    .clk(clk), .reset(reset), .inicio(inicio), .modo(modo), .A(a4), .B(b4),
    .listo(listo), .valido(valido), .MAYOR(mayor), .IGUAL(igual), .MENOR(menor),
    .Z(z), .PASOS(pasos)
  );

  // K=8 instances, M=2 and M=8, sharing stimulus
  logic       ini8 = 1'b0, modo8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       listo2, valido2, may2, igu2, men2, z2;
  logic [2:0] pasos2;
  logic       listo8, valido8, may8, igu8, men8, z8;
  logic [0:0] pasos8;

  comparador_secuencial #(.K(8), .M(2)) u_k8m2 (
    .clk(clk), .reset(reset), .inicio(ini8), .modo(modo8), .A(a8), .B(b8),
    .listo(listo2), .valido(valido2), .MAYOR(may2), .IGUAL(igu2), .MENOR(men2),
    .Z(z2), .PASOS(pasos2)
  );

  comparador_secuencial #(.K(8), .M(8)) u_k8m8 (
    .clk(clk), .reset(reset), .inicio(ini8), .modo(modo8), .A(a8), .B(b8),
    .listo(listo8), .valido(valido8), .MAYOR(may8), .IGUAL(igu8), .MENOR(men8),
    .Z(z8), .PASOS(pasos8)
  );

  esperado_t q4[$], q2[$], q8[$];

  task automatic chk(string nombre, int got, int exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, got, exp, $time);
    end
  endtask

  task automatic falla(string nombre);
    tests++;
    failed++;
    $display("FAIL %s (t=%0t)", nombre, $time);
  endtask

  // code: 0 = igual, 1 = mayor, 2 = menor
  function automatic esperado_t hacer(int code, int s, int acc);
    esperado_t e;
    e.may = (code == 1);
    e.igu = (code == 0);
    e.men = (code == 2);
    e.pasos = s;
    e.acc = acc;
    return e;
  endfunction

  task automatic verificar(string tag, esperado_t e, logic ma, logic ig, logic me,
                           logic zz, int p);
    chk({tag, "_mayor"}, int'(ma), int'(e.may));
    chk({tag, "_igual"}, int'(ig), int'(e.igu));
    chk({tag, "_menor"}, int'(me), int'(e.men));
    chk({tag, "_z"}, int'(zz), int'(e.may));
    chk({tag, "_pasos"}, p, e.pasos);
    chk({tag, "_latencia"}, ciclo - e.acc, e.pasos);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (valido) begin
      if (q4.size() == 0) falla("k4m1_valido_inesperado");
      else verificar("k4m1", q4.pop_front(), mayor, igual, menor, z, int'(pasos));
    end
    if (valido2) begin
      if (q2.size() == 0) falla("k8m2_valido_inesperado");
      else verificar("k8m2", q2.pop_front(), may2, igu2, men2, z2, int'(pasos2));
    end
    if (valido8) begin
      if (q8.size() == 0) falla("k8m8_valido_inesperado");
      else verificar("k8m8", q8.pop_front(), may8, igu8, men8, z8, int'(pasos8));
    end
  end

  // Start one K=4 comparison; returns at the negedge just after acceptance.
  task automatic lanzar4(logic [3:0] a, logic [3:0] b, logic m, int code, int s,
                         bit push);
    int n = 0;
    @(negedge clk);
    while (!listo && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!listo) falla("k4m1_timeout_listo");
    a4 = a; b4 = b; modo = m; inicio = 1'b1;
    if (push) q4.push_back(hacer(code, s, ciclo + 1));
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic lanzar8(logic [7:0] a, logic [7:0] b, logic m, int code,
                         int s2, int s8);
    int n = 0;
    @(negedge clk);
    while (!(listo2 && listo8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(listo2 && listo8)) falla("k8_timeout_listo");
    a8 = a; b8 = b; modo8 = m; ini8 = 1'b1;
    q2.push_back(hacer(code, s2, ciclo + 1));
    q8.push_back(hacer(code, s8, ciclo + 1));
    @(negedge clk);
    ini8 = 1'b0;
  endtask

  task automatic chk_reposo(string tag);
    chk({tag, "_listo"}, int'(listo), 1);
    chk({tag, "_valido"}, int'(valido), 0);
    chk({tag, "_salidas"}, int'({mayor, igual, menor, z}), 0);
    chk({tag, "_pasos"}, int'(pasos), 0);
  endtask

  initial begin
    // Reset held two cycles with inicio asserted: must be ignored
    reset = 1'b1;
    inicio = 1'b1; ini8 = 1'b1;
    a4 = 4'b1010; b4 = 4'b0110;
    repeat (2) @(negedge clk);
    chk_reposo("reset");
    chk("reset_k8_pasos", int'({pasos2, pasos8, may2, may8}), 0);
    reset = 1'b0;
    inicio = 1'b0; ini8 = 1'b0;
    @(negedge clk);
    chk_reposo("post_reset");
    repeat (2) @(negedge clk);

    // K=4, M=1 directed vectors
    lanzar4(4'b1010, 4'b0110, 1'b0, 1, 1, 1'b1);
    lanzar4(4'b1010, 4'b0110, 1'b1, 1, 4, 1'b1);
    lanzar4(4'b0011, 4'b0101, 1'b0, 2, 2, 1'b1);
    lanzar4(4'b1001, 4'b1001, 1'b0, 0, 4, 1'b1);
    lanzar4(4'b1001, 4'b1001, 1'b1, 0, 4, 1'b1);
    lanzar4(4'b0001, 4'b0000, 1'b0, 1, 4, 1'b1);
    lanzar4(4'b0111, 4'b1000, 1'b1, 2, 4, 1'b1);

    // Inputs toggled and inicio pulsed during COMPARA: result unchanged
    lanzar4(4'b1010, 4'b0110, 1'b1, 1, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a4 = 4'b0000; b4 = 4'b1111; modo = ~modo; inicio = 1'b1;
      @(negedge clk);
    end
    inicio = 1'b0;

    // Reset in the second COMPARA cycle: abandoned, no valido
    lanzar4(4'b0111, 4'b1000, 1'b1, 2, 4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reposo("reset_mid");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    lanzar4(4'b0011, 4'b0101, 1'b0, 2, 2, 1'b1);

    // K=8, M=2 and M=8
    lanzar8(8'hC3, 8'hC1, 1'b0, 1, 4, 1);
    lanzar8(8'hFF, 8'h00, 1'b0, 1, 1, 1);
    lanzar8(8'h00, 8'hFF, 1'b1, 2, 4, 1);
    lanzar8(8'h5A, 8'h5A, 1'b0, 0, 4, 1);
    lanzar8(8'h1C, 8'h2C, 1'b1, 2, 4, 1);

    // Drain scoreboards
    begin
      int n = 0;
      while ((q4.size() + q2.size() + q8.size()) != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if ((q4.size() + q2.size() + q8.size()) != 0) falla("drain_timeout");
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
